lsu_byte_serial: RTL and testbench

Parametrised load/store stage between the EX/MEM and MEM/WB pipeline registers. Non-memory instructions pass straight through. Loads and stores of 1, 2 or 4 bytes run as byte-serial transfers over an arbitrated 8-bit memory port with a configurable read latency. The block holds the pipeline with `stall_o` until the transfer completes, assembles loads little-endian, and zero- or sign-extends them. Misaligned or invalid accesses are rejected without touching memory.

---
 rtl/lsu_byte_serial_if.sv | 33 +++
 rtl/lsu_byte_serial.sv | 249 ++++++++++++++++++++++++
 tb/tb_lsu_byte_serial.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_byte_serial_if.sv
// Byte-wide memory port between the load/store stage and the memory arbiter.
// Latency: n/a (signal bundle only).
// Backpressure: the arbiter grants by holding mem_gnt_i high while mem_req_o is high.
interface lsu_byte_serial_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [ADDR_W-1:0] mem_a_o;
    logic              mem_wr_o;
    logic [7:0]        mem_dout_o;
    logic [7:0]        mem_din_i;

    // Load/store stage side
    modport master (
        output mem_req_o,
        output mem_a_o,
        output mem_wr_o,
        output mem_dout_o,
        input  mem_gnt_i,
        input  mem_din_i
    );

    // Arbiter / memory side
    modport slave (
        input  mem_req_o,
        input  mem_a_o,
        input  mem_wr_o,
        input  mem_dout_o,
        output mem_gnt_i,
        output mem_din_i
    );
endinterface

// File: rtl/lsu_byte_serial.sv
// Load/store stage: ALU results pass through; 1/2/4-byte accesses run byte-serially on an 8-bit port.
// Latency: pass-through and rejects 0 cycles; store g+N+1, load g+N+RD_LAT+1 cycles (g = first grant cycle).
// Backpressure: stall_o holds the upstream pipeline until DONE; grant loss repeats the current byte.
module lsu_byte_serial #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       rd_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_enable_i,
    input  logic                  load_i,
    input  logic                  store_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    output logic [XLEN-1:0]       rd_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  rd_enable_o,
    output logic                  stall_o,
    output logic                  misalign_o,
    lsu_byte_serial_if.master     mem_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Request decode (only meaningful while IDLE; inputs are held while stalled)
    logic       mem_op;
    logic       is_load;
    logic       legal_f3;
    logic       misaligned;
    logic       reject;
    logic       accept;
    logic [2:0] dec_n;

    // Captured transfer context
    logic [ADDR_W-1:0]     base_q;
    logic [2:0]            n_q;
    logic                  load_q;
    logic                  uns_q;
    logic [31:0]           sdata_q;
    logic [REG_ADDR_W-1:0] rdaddr_q;
    logic [2:0]            k_q;
    logic [31:0]           ldata_q;

    // Read-return tracking: one slot per cycle of read latency
    logic       pv_q [RD_LAT];
    logic [1:0] pk_q [RD_LAT];

    logic            k_last;
    logic            rd_issue;
    logic            cap_vld;
    logic [1:0]      cap_k;
    logic            last_cap;
    logic [XLEN-1:0] ld_ext;

    assign mem_op   = load_i | store_i;
    assign is_load  = load_i;
    assign k_last   = (k_q == (n_q - 3'd1));
    assign rd_issue = (state == S_XFER) && mem_if.mem_gnt_i && load_q;
    assign cap_vld  = pv_q[RD_LAT-1];
    assign cap_k    = pk_q[RD_LAT-1];
    assign last_cap = cap_vld && ({1'b0, cap_k} == (n_q - 3'd1));
    assign accept   = mem_op && !reject;

    // Decode access size, funct3 legality and alignment of the presented access
    always_comb begin
        dec_n = 3'd0;
        case (funct3_i[1:0])
            2'b00:   dec_n = 3'd1;
            2'b01:   dec_n = 3'd2;
            2'b10:   dec_n = 3'd4;
            default: dec_n = 3'd0;
        endcase
        if (is_load) begin
            legal_f3 = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else begin
            legal_f3 = funct3_i inside {3'b000, 3'b001, 3'b010};
        end
        misaligned = ((dec_n == 3'd2) && mem_addr_i[0]) ||
                     ((dec_n == 3'd4) && (mem_addr_i[1:0] != 2'b00));
        reject     = mem_op && (!legal_f3 || misaligned);
    end

    // Extend the assembled load value to register width
    always_comb begin
        ld_ext       = '0;
        ld_ext[31:0] = ldata_q;
        if (n_q == 3'd1) begin
            ld_ext = {{(XLEN-8){ldata_q[7] & ~uns_q}}, ldata_q[7:0]};
        end else if (n_q == 3'd2) begin
            ld_ext = {{(XLEN-16){ldata_q[15] & ~uns_q}}, ldata_q[15:0]};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and all block outputs; everything forced to zero during reset
    always_comb begin
        state_nxt         = state;
        rd_data_o         = '0;
        rd_addr_o         = '0;
        rd_enable_o       = 1'b0;
        stall_o           = 1'b0;
        misalign_o        = 1'b0;
        mem_if.mem_req_o  = 1'b0;
        mem_if.mem_a_o    = '0;
        mem_if.mem_wr_o   = 1'b0;
        mem_if.mem_dout_o = 8'h00;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_if.mem_gnt_i) begin
                    state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (!mem_if.mem_gnt_i) begin
                    state_nxt = S_REQ;
                end else if (k_last) begin
                    state_nxt = load_q ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (last_cap) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (!mem_op) begin
                        rd_data_o   = rd_data_i;
                        rd_addr_o   = rd_addr_i;
                        rd_enable_o = rd_enable_i;
                    end else if (reject) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                S_REQ: begin
                    stall_o          = 1'b1;
                    mem_if.mem_req_o = 1'b1;
                end
                S_XFER: begin
                    stall_o           = 1'b1;
                    mem_if.mem_req_o  = 1'b1;
                    mem_if.mem_a_o    = base_q + ADDR_W'(k_q);
                    mem_if.mem_wr_o   = ~load_q;
                    mem_if.mem_dout_o = load_q ? 8'h00 : sdata_q[{k_q[1:0], 3'b000} +: 8];
                end
                S_WAIT: begin
                    stall_o = 1'b1;
                end
                S_DONE: begin
                    if (load_q) begin
                        rd_data_o   = ld_ext;
                        rd_addr_o   = rdaddr_q;
                        rd_enable_o = rd_enable_i;
                    end
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

    // Capture transfer context on accept, advance the byte counter on granted beats, assemble load bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            n_q      <= 3'd0;
            load_q   <= 1'b0;
            uns_q    <= 1'b0;
            sdata_q  <= 32'h0;
            rdaddr_q <= '0;
            k_q      <= 3'd0;
            ldata_q  <= 32'h0;
        end else begin
            if ((state == S_IDLE) && accept) begin
                base_q   <= mem_addr_i;
                n_q      <= dec_n;
                load_q   <= is_load;
                uns_q    <= funct3_i[2];
                sdata_q  <= rd_data_i[31:0];
                rdaddr_q <= rd_addr_i;
                k_q      <= 3'd0;
                ldata_q  <= 32'h0;
            end else begin
                if ((state == S_XFER) && mem_if.mem_gnt_i) begin
                    k_q <= k_q + 3'd1;
                end
                if (cap_vld) begin
                    ldata_q[{cap_k, 3'b000} +: 8] <= mem_if.mem_din_i;
                end
            end
        end
    end

    // Delay line marking which byte index returns on mem_din_i in each cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pk_q[i] <= 2'd0;
            end
        end else begin
            pv_q[0] <= rd_issue;
            pk_q[0] <= k_q[1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pk_q[i] <= pk_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_lsu_byte_serial.sv
module tb_lsu_byte_serial;
    localparam int RD_LAT = 2;

    logic        clk;
    logic        rst;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_enable_i;
    logic        load_i;
    logic        store_i;
    logic [2:0]  funct3_i;
    logic [31:0] mem_addr_i;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_enable_o;
    logic        stall_o;
    logic        misalign_o;
    logic        gnt_en;

    lsu_byte_serial_if #(.ADDR_W(32)) mem_if ();

    lsu_byte_serial #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
        .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i), .mem_addr_i(mem_addr_i),
        .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
        .stall_o(stall_o), .misalign_o(misalign_o), .mem_if(mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_if.mem_gnt_i = gnt_en & mem_if.mem_req_o;

    // Memory behind the arbiter, and an independent reference copy for the model
    logic [7:0] tmem    [4096];
    logic [7:0] ref_mem [4096];
    logic [7:0] pend_d  [8];
    logic       pend_v  [8];

    typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
    wr_t wlog[$];

    int tcyc = 0;
    int op_start = 0;
    int req_cnt = 0;
    int nvec = 0;
    int nbad = 0;

    always @(negedge clk) begin
        if (mem_if.mem_req_o) begin
            req_cnt++;
            if (mem_if.mem_gnt_i) begin
                if (mem_if.mem_wr_o) begin
                    tmem[mem_if.mem_a_o[11:0]] = mem_if.mem_dout_o;
                    wlog.push_back('{a: mem_if.mem_a_o, d: mem_if.mem_dout_o, cyc: tcyc - op_start});
                end else begin
                    pend_v[(tcyc + RD_LAT) % 8] = 1'b1;
                    pend_d[(tcyc + RD_LAT) % 8] = tmem[mem_if.mem_a_o[11:0]];
                end
            end
        end
    end

    always @(posedge clk) begin
        tcyc++;
        #1;
        if (pend_v[tcyc % 8]) mem_if.mem_din_i = pend_d[tcyc % 8];
        else                  mem_if.mem_din_i = 8'($urandom);
        pend_v[tcyc % 8] = 1'b0;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rda;
        logic        rde;
        int          gmode;     // 0: random grant, k>0: grant from op cycle k on
        logic        exp_rej;
        logic [31:0] exp_data;
        int          exp_done;  // -1: not checked
    } vec_t;

    task automatic apply(input vec_t v, input bit hand);
        logic mem_op, legal, rej_m, mis0, busy_bad, den;
        logic [31:0] exp_m, dq, ea;
        logic [4:0] da;
        longint lv;
        int n, done, g;
        mem_op = v.ld | v.st;
        legal = v.ld ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 inside {3'd0, 3'd1, 3'd2});
        n = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        rej_m = mem_op && (!legal || (v.addr % n) != 0);
        lv = 0;
        for (int i = 0; i < n; i++) lv = lv | (longint'(ref_mem[(v.addr + 32'(i)) & 32'hFFF]) << (8 * i));
        if (!v.f3[2] && n < 4 && lv >= (longint'(1) << (8 * n - 1))) lv = lv - (longint'(1) << (8 * n));
        exp_m = lv[31:0];

        load_i = v.ld; store_i = v.st; funct3_i = v.f3; mem_addr_i = v.addr;
        rd_data_i = v.wdata; rd_addr_i = v.rda; rd_enable_i = v.rde;
        wlog.delete(); req_cnt = 0; op_start = tcyc; busy_bad = 0; done = -1;
        mis0 = 0; dq = 0; den = 0; da = 0;
        for (int c = 0; c < 300; c++) begin
            gnt_en = (v.gmode == 0) ? ($urandom_range(0, 9) < 7) : (c >= v.gmode);
            @(negedge clk);
            if (c == 0) mis0 = misalign_o;
            if (!stall_o) begin
                done = c; dq = rd_data_o; den = rd_enable_o; da = rd_addr_o;
                break;
            end
            if (rd_enable_o || rd_data_o != 0 || misalign_o) busy_bad = 1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        check("misalign", 64'(mis0), 64'(rej_m));
        if (!mem_op) begin
            check("pass_data", 64'(dq), 64'(v.wdata));
            check("pass_addr", 64'(da), 64'(v.rda));
            check("pass_en", 64'(den), 64'(v.rde));
            check("pass_req", 64'(req_cnt), 64'd0);
        end else if (rej_m) begin
            check("rej_stall", 64'(done), 64'd0);
            check("rej_en", 64'(den), 64'd0);
            check("rej_req", 64'(req_cnt), 64'd0);
        end else begin
            check("timeout", 64'(done >= 0), 64'd1);
            check("busy_outputs", 64'(busy_bad), 64'd0);
            check("done_en", 64'(den), 64'(v.ld & v.rde));
            if (v.ld) begin
                check("load_data", 64'(dq), 64'(exp_m));
                if (v.rde) check("load_addr", 64'(da), 64'(v.rda));
            end else begin
                check("wlog_size", 64'(wlog.size()), 64'(n));
                g = (v.gmode < 1) ? 1 : v.gmode;
                for (int i = 0; i < n && i < wlog.size(); i++) begin
                    ea = v.addr + 32'(i);
                    check("store_byte", {wlog[i].a, 24'h0, wlog[i].d}, {ea, 24'h0, v.wdata[8*i +: 8]});
                    if (v.gmode > 0) check("store_cycle", 64'(wlog[i].cyc), 64'(g + 1 + i));
                    ref_mem[ea & 32'hFFF] = v.wdata[8*i +: 8];
                end
            end
        end
        if (hand) begin
            check("hand_reject", 64'(mis0), 64'(v.exp_rej));
            if (v.exp_done >= 0) check("hand_done_cycle", 64'(done), 64'(v.exp_done));
            if (!v.exp_rej && !v.st) check("hand_data", 64'(dq), 64'(v.exp_data));
        end
    endtask

    vec_t tbl[$];
    logic [2:0] ld_codes[5];

    initial begin
        vec_t v;
        for (int i = 0; i < 4096; i++) begin tmem[i] = 8'h00; ref_mem[i] = 8'h00; end
        for (int i = 0; i < 8; i++) begin pend_v[i] = 1'b0; pend_d[i] = 8'h00; end
        tmem[12'h201] = 8'h80; ref_mem[12'h201] = 8'h80;
        {tmem[12'h303], tmem[12'h302], tmem[12'h301], tmem[12'h300]} = 32'h89ABCDEF;
        {ref_mem[12'h303], ref_mem[12'h302], ref_mem[12'h301], ref_mem[12'h300]} = 32'h89ABCDEF;
        ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        // Reset: outputs zero even with an ALU op presented
        rst = 1; gnt_en = 1; mem_if.mem_din_i = 8'h00;
        load_i = 0; store_i = 0; funct3_i = 0; mem_addr_i = 0;
        rd_data_i = 32'h1234; rd_addr_i = 5; rd_enable_i = 1;
        @(posedge clk); #1; @(posedge clk); #1;
        @(negedge clk);
        check("rst_rd_data", 64'(rd_data_o), 64'd0);
        check("rst_rd_addr", 64'(rd_addr_o), 64'd0);
        check("rst_rd_en", 64'({rd_enable_o, stall_o, misalign_o}), 64'd0);
        check("rst_mem", {mem_if.mem_req_o, mem_if.mem_wr_o, mem_if.mem_dout_o, mem_if.mem_a_o}, 64'd0);
        @(posedge clk); #1;
        rst = 0;

        //           ld st f3    addr        wdata         rda rde g  rej exp_data      done
        tbl.push_back('{0, 0, 3'd0, 32'h0,     32'h1234,     5, 1, 1, 0, 32'h1234,     0});
        tbl.push_back('{0, 1, 3'd2, 32'h100,   32'hDEADBEEF, 0, 0, 1, 0, 32'h0,        6});
        tbl.push_back('{1, 0, 3'd0, 32'h201,   32'h0,        3, 1, 1, 0, 32'hFFFFFF80, 5});
        tbl.push_back('{1, 0, 3'd4, 32'h201,   32'h0,        4, 1, 1, 0, 32'h00000080, 5});
        tbl.push_back('{1, 0, 3'd1, 32'h203,   32'h0,        4, 1, 1, 1, 32'h0,        0});
        tbl.push_back('{0, 1, 3'd2, 32'h102,   32'h55,       0, 0, 1, 1, 32'h0,        0});
        tbl.push_back('{1, 0, 3'd2, 32'h300,   32'h0,        7, 1, 4, 0, 32'h89ABCDEF, 11});
        tbl.push_back('{1, 0, 3'd1, 32'h300,   32'h0,        8, 1, 1, 0, 32'hFFFFCDEF, 6});
        tbl.push_back('{1, 0, 3'd5, 32'h302,   32'h0,        9, 0, 1, 0, 32'h000089AB, 6});
        tbl.push_back('{1, 0, 3'd3, 32'h300,   32'h0,        1, 1, 1, 1, 32'h0,        0});
        tbl.push_back('{0, 1, 3'd4, 32'h300,   32'h0,        1, 1, 1, 1, 32'h0,        0});
        tbl.push_back('{1, 1, 3'd2, 32'h300,   32'h0,        2, 1, 1, 0, 32'h89ABCDEF, 8});
        tbl.push_back('{0, 1, 3'd1, 32'h402,   32'hA5A51357, 0, 0, 1, 0, 32'h0,        4});
        tbl.push_back('{0, 1, 3'd0, 32'h403,   32'h00000077, 0, 0, 2, 0, 32'h0,        4});
        tbl.push_back('{1, 0, 3'd2, 32'h400,   32'h0,        10, 1, 1, 0, 32'h77570000, 8});
        foreach (tbl[i]) apply(tbl[i], 1'b1);

        // Reset in the middle of a SW, after two bytes are written
        load_i = 0; store_i = 1; funct3_i = 3'd2; mem_addr_i = 32'h500;
        rd_data_i = 32'h11223344; rd_addr_i = 0; rd_enable_i = 0; gnt_en = 1;
        wlog.delete(); op_start = tcyc;
        for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
        rst = 1; store_i = 0; rd_data_i = 0; mem_addr_i = 0; funct3_i = 0;
        @(negedge clk);
        check("rst_mid_req", 64'({mem_if.mem_req_o, stall_o}), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("after_rst_out", {mem_if.mem_req_o, mem_if.mem_wr_o, stall_o, misalign_o,
                                rd_enable_o, mem_if.mem_a_o}, 64'd0);
        check("rst_bytes_written", 64'(wlog.size()), 64'd2);
        check("rst_byte2_untouched", 64'(tmem[12'h502]), 64'h00);
        ref_mem[12'h500] = 8'h44; ref_mem[12'h501] = 8'h33;
        @(posedge clk); #1;
        v = '{1, 0, 3'd2, 32'h500, 32'h0, 6, 1, 1, 0, 32'h00003344, 8};
        apply(v, 1'b1);

        // Randomised operations with random grant loss, checked against the reference model
        for (int r = 0; r < 150; r++) begin
            int kind;
            kind = $urandom_range(0, 4);
            v.ld = (kind == 1 || kind == 2);
            v.st = (kind >= 3) || (v.ld && $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) v.f3 = 3'($urandom_range(0, 7));
            else if (v.ld)                 v.f3 = ld_codes[$urandom_range(0, 4)];
            else                           v.f3 = 3'($urandom_range(0, 2));
            v.addr = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) v.addr = v.addr & 32'hFFC;
            v.wdata = $urandom;
            v.rda = 5'($urandom_range(0, 31));
            v.rde = 1'($urandom_range(0, 1));
            v.gmode = 0; v.exp_rej = 0; v.exp_data = 0; v.exp_done = -1;
            apply(v, 1'b0);
        end

        load_i = 0; store_i = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
